// File: rtl/btn_press_gen_pkg.sv
// Shared types and defaults for the emulated push-button press generator.
package btn_press_gen_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_PRESS  = 2'd1,
    ST_GAP    = 2'd2,
    ST_FINISH = 2'd3
  } state_t;

  localparam int unsigned DEF_CNT_W        = 4;
  localparam int unsigned DEF_PRESS_CYCLES = 4;
  localparam int unsigned DEF_GAP_CYCLES   = 4;

  // Bits needed to hold the larger of the two phase lengths.
  function automatic int unsigned timer_width(input int unsigned press_cycles,
                                              input int unsigned gap_cycles);
    int unsigned longest;
    longest = (press_cycles > gap_cycles) ? press_cycles : gap_cycles;
    return $clog2(longest + 1);
  endfunction

endpackage

// File: rtl/btn_press_gen_cycle_timer.sv
// Loadable down-counter timing the PRESS and GAP phases.
// last is high while the count sits at zero, i.e. in the final cycle of a phase
// that was loaded with (length - 1).
module cycle_timer #(
  parameter int unsigned W = 3
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         last
);

  logic [W-1:0] count;

  // Load on strobe, otherwise count down and hold at zero.
  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (count != '0) begin
      count <= count - W'(1);
    end
  end

  assign last = (count == '0);

endmodule

// File: rtl/btn_press_gen.sv
// Emits N clean active-low press pulses with programmable press/gap widths.
// Optional feature: define BTN_PRESS_ABORT_EN to add abort_i, which cuts a
// running sequence short (button released, remaining cleared, done_o pulsed).
module btn_press_gen
  import btn_press_gen_pkg::*;
#(
  parameter int unsigned CNT_W        = DEF_CNT_W,
  parameter int unsigned PRESS_CYCLES = DEF_PRESS_CYCLES,
  parameter int unsigned GAP_CYCLES   = DEF_GAP_CYCLES
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic [CNT_W-1:0] count_i,
`ifdef BTN_PRESS_ABORT_EN
  input  logic             abort_i,
`endif
  output logic             busy_o,
  output logic             done_o,
  output logic [CNT_W-1:0] remaining_o,
  output logic             btn_n_o
);

  localparam int unsigned TMR_W = timer_width(PRESS_CYCLES, GAP_CYCLES);
  localparam logic [TMR_W-1:0] PRESS_LOAD = TMR_W'(PRESS_CYCLES - 1);
  localparam logic [TMR_W-1:0] GAP_LOAD   = TMR_W'(GAP_CYCLES - 1);

  state_t           state, state_next;
  logic [CNT_W-1:0] remaining, rem_next;
  logic             tmr_load;
  logic [TMR_W-1:0] tmr_val;
  logic             tmr_last;
  logic             busy_next, done_next, btn_n_next;

`ifdef BTN_PRESS_ABORT_EN
  // Set for the first FINISH cycle after an abort so done_o is delayed by one.
  logic             abort_hold, hold_next;
`endif

  cycle_timer #(
    .W(TMR_W)
  ) u_timer (
    .clk      (clk_i),
    .rst      (rst_i),
    .load     (tmr_load),
    .load_val (tmr_val),
    .last     (tmr_last)
  );

  // Next-state, remaining-count and timer-load decisions.
  always_comb begin
    state_next = state;
    rem_next   = remaining;
    tmr_load   = 1'b0;
    tmr_val    = '0;
`ifdef BTN_PRESS_ABORT_EN
    hold_next  = 1'b0;
`endif
    unique case (state)
      ST_IDLE: begin
        if (start_i) begin
          rem_next = count_i;
          if (count_i != '0) begin
            state_next = ST_PRESS;
            tmr_load   = 1'b1;
            tmr_val    = PRESS_LOAD;
          end else begin
            state_next = ST_FINISH;
          end
        end
      end
      ST_PRESS: begin
        if (tmr_last) begin
          if (remaining != '0) begin
            rem_next = remaining - CNT_W'(1);
          end
          state_next = ST_GAP;
          tmr_load   = 1'b1;
          tmr_val    = GAP_LOAD;
        end
      end
      ST_GAP: begin
        if (tmr_last) begin
          if (remaining != '0) begin
            state_next = ST_PRESS;
            tmr_load   = 1'b1;
            tmr_val    = PRESS_LOAD;
          end else begin
            state_next = ST_FINISH;
          end
        end
      end
      ST_FINISH: begin
`ifdef BTN_PRESS_ABORT_EN
        if (abort_hold) begin
          state_next = ST_FINISH;
        end else begin
          state_next = ST_IDLE;
        end
`else
        state_next = ST_IDLE;
`endif
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
`ifdef BTN_PRESS_ABORT_EN
    if (abort_i && (state == ST_PRESS || state == ST_GAP)) begin
      state_next = ST_FINISH;
      rem_next   = '0;
      tmr_load   = 1'b0;
      hold_next  = 1'b1;
    end
`endif
  end

  // Outputs are registered copies derived from the upcoming state.
  always_comb begin
    btn_n_next = (state_next != ST_PRESS);
    busy_next  = (state_next == ST_PRESS) || (state_next == ST_GAP);
`ifdef BTN_PRESS_ABORT_EN
    done_next  = (state_next == ST_FINISH) && !hold_next;
`else
    done_next  = (state_next == ST_FINISH);
`endif
  end

  // State, count and output registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state     <= ST_IDLE;
      remaining <= '0;
      btn_n_o   <= 1'b1;
      busy_o    <= 1'b0;
      done_o    <= 1'b0;
    end else begin
      state     <= state_next;
      remaining <= rem_next;
      btn_n_o   <= btn_n_next;
      busy_o    <= busy_next;
      done_o    <= done_next;
    end
  end

`ifdef BTN_PRESS_ABORT_EN
  // Abort hold flag.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      abort_hold <= 1'b0;
    end else begin
      abort_hold <= hold_next;
    end
  end
`endif

  assign remaining_o = remaining;

endmodule

// File: tb/tb_btn_press_gen.sv
// Self-checking bench for btn_press_gen: schedule-based reference model plus
// literal timing pins for the directed sequences.
module tb_btn_press_gen;

  localparam int CNT_W = 4;
  localparam int P     = 4;
  localparam int G     = 4;
  localparam int L     = P + G;

  logic             clk;
  logic             rst;
  logic             start;
  logic [CNT_W-1:0] count;
  logic             abort;
  logic             busy, done, btn_n;
  logic [CNT_W-1:0] rem;

  int checks = 0;
  int errors = 0;

  btn_press_gen #(
    .CNT_W        (CNT_W),
    .PRESS_CYCLES (P),
    .GAP_CYCLES   (G)
  ) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .start_i     (start),
    .count_i     (count),
`ifdef BTN_PRESS_ABORT_EN
    .abort_i     (abort),
`endif
    .busy_o      (busy),
    .done_o      (done),
    .remaining_o (rem),
    .btn_n_o     (btn_n)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: mode 0 idle, 1 running sequence, 2 aborting.
  // t is the 1-based cycle index since the accepted start edge.
  int   mode = 0;
  int   n, t, ab, idx;
  bit   model_ok = 0;
  logic exp_btn, exp_busy, exp_done;
  int   exp_rem;

  always @(posedge clk) begin
    if (rst) begin
      mode = 0;
    end else begin
      case (mode)
        0: if (start) begin n = int'(count); t = 1; mode = 1; end
        1: begin
`ifdef BTN_PRESS_ABORT_EN
          if (abort && t <= n * L) begin
            mode = 2;
            ab   = 1;
          end else begin
            t++;
          end
`else
          t++;
`endif
        end
        2: ab++;
        default: mode = 0;
      endcase
    end
    exp_btn  = 1'b1;
    exp_busy = 1'b0;
    exp_done = 1'b0;
    exp_rem  = 0;
    if (mode == 1) begin
      if (t <= n * L) begin
        idx      = (t - 1) % L;
        exp_busy = 1'b1;
        exp_btn  = (idx < P) ? 1'b0 : 1'b1;
        exp_rem  = n - ((t - 1) / L + ((idx >= P) ? 1 : 0));
      end else if (t == n * L + 1) begin
        exp_done = 1'b1;
      end else begin
        mode = 0;
      end
    end else if (mode == 2) begin
      if (ab == 2) exp_done = 1'b1;
      else if (ab >= 3) mode = 0;
    end
    model_ok = 1;
  end

  // Per-cycle comparison against the model.
  always @(negedge clk) begin
    if (model_ok) begin
      chk("btn_n", btn_n, exp_btn);
      chk("busy", busy, exp_busy);
      chk("done", done, exp_done);
      chk("remaining", rem, exp_rem);
    end
  end

  task automatic go(input int cnt);
    start = 1'b1;
    count = CNT_W'(cnt);
    @(posedge clk);
  endtask

  int pulses;
  int done_seen;
  logic prev_btn;

  initial begin
    rst = 1'b1; start = 1'b0; count = '0; abort = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;

    // Idle after reset.
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      chk("idle_btn", btn_n, 1);
      chk("idle_busy", busy, 0);
      chk("idle_done", done, 0);
      chk("idle_rem", rem, 0);
    end

    // Three presses with default timing.
    go(3);
    for (int c = 1; c <= 26; c++) begin
      @(negedge clk);
      if (c == 1) start = 1'b0;
      if (c == 1)  begin chk("s2_c1_btn", btn_n, 0); chk("s2_c1_busy", busy, 1); chk("s2_c1_rem", rem, 3); end
      if (c == 4)  chk("s2_c4_btn", btn_n, 0);
      if (c == 5)  begin chk("s2_c5_btn", btn_n, 1); chk("s2_c5_rem", rem, 2); end
      if (c == 9)  chk("s2_c9_btn", btn_n, 0);
      if (c == 13) chk("s2_c13_rem", rem, 1);
      if (c == 20) chk("s2_c20_btn", btn_n, 0);
      if (c == 21) chk("s2_c21_rem", rem, 0);
      if (c == 24) begin chk("s2_c24_busy", busy, 1); chk("s2_c24_done", done, 0); end
      if (c == 25) begin chk("s2_c25_done", done, 1); chk("s2_c25_busy", busy, 0); end
      if (c == 26) chk("s2_c26_done", done, 0);
    end

    // Zero-count request.
    go(0);
    for (int c = 1; c <= 3; c++) begin
      @(negedge clk);
      if (c == 1) begin
        start = 1'b0;
        chk("s3_done", done, 1); chk("s3_busy", busy, 0); chk("s3_btn", btn_n, 1);
      end
      if (c == 2) chk("s3_done_off", done, 0);
    end

    // Second request while busy is ignored.
    go(2);
    pulses = 0; prev_btn = 1'b1;
    for (int c = 1; c <= 22; c++) begin
      @(negedge clk);
      if (c == 1) start = 1'b0;
      if (c == 6) begin start = 1'b1; count = 4'd5; end
      if (c == 7) start = 1'b0;
      if (prev_btn && !btn_n) pulses++;
      prev_btn = btn_n;
    end
    chk("s4_pulses", pulses, 2);
    chk("s4_rem", rem, 0);

    // Reset in the middle of a long sequence.
    go(15);
    done_seen = 0;
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      if (c == 1) start = 1'b0;
      if (c == 10) rst = 1'b1;
      if (c == 11) begin
        rst = 1'b0;
        chk("s5_btn", btn_n, 1); chk("s5_busy", busy, 0);
      end
      if (c > 10 && done) done_seen++;
    end
    chk("s5_no_done", done_seen, 0);
    go(1);
    pulses = 0; prev_btn = 1'b1;
    for (int c = 1; c <= 12; c++) begin
      @(negedge clk);
      if (c == 1) start = 1'b0;
      if (prev_btn && !btn_n) pulses++;
      prev_btn = btn_n;
    end
    chk("s5_fresh_pulses", pulses, 1);

`ifdef BTN_PRESS_ABORT_EN
    // Abort during the first gap.
    go(4);
    pulses = 0; prev_btn = 1'b1;
    for (int c = 1; c <= 12; c++) begin
      @(negedge clk);
      if (c == 1) start = 1'b0;
      if (c == 6) abort = 1'b1;
      if (c == 7) begin abort = 1'b0; chk("s6_btn", btn_n, 1); chk("s6_rem", rem, 0); end
      if (c == 8) chk("s6_done", done, 1);
      if (prev_btn && !btn_n) pulses++;
      prev_btn = btn_n;
    end
    chk("s6_pulses", pulses, 1);
`endif

    // Randomized traffic checked by the model.
    for (int i = 0; i < 4000; i++) begin
      @(negedge clk);
      start = ($urandom_range(0, 5) == 0);
      case ($urandom_range(0, 3))
        0:       count = '0;
        1:       count = '1;
        default: count = CNT_W'($urandom_range(0, 4));
      endcase
      rst = ($urandom_range(0, 299) == 0);
`ifdef BTN_PRESS_ABORT_EN
      abort = ($urandom_range(0, 59) == 0);
`endif
    end
    start = 1'b0; rst = 1'b0; abort = 1'b0;
    repeat (3) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
